// File: rtl/count_ctrl.sv
`timescale 1ns/1ps
// count_ctrl: start/stop/pause controller that drives an external 16-bit counter through a
// programmable prescaler. Optional macro COUNT_CTRL_AUTO_RELOAD_EN makes a terminal count restart the run.
module count_ctrl #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             Clk,
   input  logic             Resetn,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [15:0]      target,
   input  logic [DIV_W-1:0] div,
   input  logic [15:0]      q,
   output logic             cnt_en,
   output logic             cnt_clr,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HOLD = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   presc_q, presc_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   target_q, target_d;
   logic               cnt_clr_q, cnt_clr_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic               tick;
   logic               at_target;
   logic               terminal;
   logic [DIV_W-1:0]   presc_step;

   // Terminal compare is blanked while the counter is being cleared (q is stale that cycle).
   assign tick       = (presc_q == div_q);
   assign at_target  = (q == target_q);
   assign terminal   = ~cnt_clr_q & at_target;
   assign presc_step = tick ? '0 : presc_q + DIV_W'(1);

   assign cnt_en  = (state_q == S_RUN) & tick & ~cnt_clr_q & ~at_target;
   assign cnt_clr = cnt_clr_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign state   = state_q;

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         div_q     <= '0;
         target_q  <= '0;
         cnt_clr_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         div_q     <= div_d;
         target_q  <= target_d;
         cnt_clr_q <= cnt_clr_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state and registered-output logic; priority in RUN is stop > terminal > pause.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      div_d     = div_q;
      target_d  = target_q;
      cnt_clr_d = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (start) begin
               state_d   = S_RUN;
               target_d  = target;
               div_d     = div;
               presc_d   = '0;
               cnt_clr_d = 1'b1;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (terminal) begin
`ifdef COUNT_CTRL_AUTO_RELOAD_EN
               done_d    = 1'b1;
               cnt_clr_d = 1'b1;
               presc_d   = '0;
`else
               state_d   = S_DONE;
               done_d    = 1'b1;
`endif
            end else begin
               // The cycle that samples pause is still a RUN cycle, so the prescaler advances once more.
               presc_d = presc_step;
               if (pause) begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (!pause) begin
               state_d = S_RUN;
            end
         end
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
   end

endmodule

// File: tb/tb_count_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for count_ctrl with a behavioural counter on q and a done-event scoreboard.
module tb_count_ctrl;

   localparam int unsigned DIV_W = 8;
`ifdef COUNT_CTRL_AUTO_RELOAD_EN
   localparam logic [1:0] DONE_ST = 2'b01;
`else
   localparam logic [1:0] DONE_ST = 2'b11;
`endif

   logic             Clk = 1'b0;
   logic             Resetn;
   logic             start, stop, pause;
   logic [15:0]      target;
   logic [DIV_W-1:0] div;
   logic [15:0]      q_m = '0;
   logic             cnt_en, cnt_clr, busy, done;
   logic [1:0]       state;

   count_ctrl #(.DIV_W(DIV_W)) dut (
      .Clk     (Clk),
      .Resetn  (Resetn),
      .start   (start),
      .stop    (stop),
      .pause   (pause),
      .target  (target),
      .div     (div),
      .q       (q_m),
      .cnt_en  (cnt_en),
      .cnt_clr (cnt_clr),
      .busy    (busy),
      .done    (done),
      .state   (state)
   );

   always #5 Clk = ~Clk;

   // External counter controlled by the DUT.
   always @(posedge Clk) begin
      if (cnt_clr)     q_m <= '0;
      else if (cnt_en) q_m <= q_m + 16'd1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      int incs;
      int qv;
      int gap;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   en_cnt = 0;
   int   last_en = -1;
   int   min_gap = 1000;
   int   max_gap = 0;
   int   q_max = 0;
   int   g;

   // Monitor: on every done pulse pop the expected run result and compare.
   initial begin
      forever begin
         @(negedge Clk);
         cyc++;
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("done_unexpected", 32'(done), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("run_incs", 32'(en_cnt), 32'(mon_e.incs));
               chk("run_q_final", 32'(q_m), 32'(mon_e.qv));
               chk("run_q_max", 32'(q_max), 32'(mon_e.qv));
               chk("run_done_state", 32'(state), 32'(DONE_ST));
               if (mon_e.gap != 0 && mon_e.incs >= 2) begin
                  chk("run_gap_min", 32'(min_gap), 32'(mon_e.gap));
                  chk("run_gap_max", 32'(max_gap), 32'(mon_e.gap));
               end
            end
         end
         if (cnt_clr === 1'b1) begin
            en_cnt  = 0;
            last_en = -1;
            min_gap = 1000;
            max_gap = 0;
            q_max   = 0;
         end else begin
            if (int'(q_m) > q_max) q_max = int'(q_m);
            if (cnt_en === 1'b1) begin
               en_cnt++;
               if (last_en >= 0) begin
                  g = cyc - last_en;
                  if (g < min_gap) min_gap = g;
                  if (g > max_gap) max_gap = g;
               end
               last_en = cyc;
            end
         end
      end
   end

   task automatic push_exp(input int incs, input int qv, input int gap);
      exp_t e;
      e.incs = incs;
      e.qv   = qv;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge of the first RUN (clear) cycle.
   task automatic launch(input logic [15:0] t, input logic [DIV_W-1:0] d);
      target = t;
      div    = d;
      start  = 1'b1;
      @(negedge Clk);
      start  = 1'b0;
      chk("launch_clr", 32'(cnt_clr), 32'd1);
      chk("launch_state", 32'(state), 32'd1);
      chk("launch_busy", 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input int max_cyc);
      int n = 0;
      while (done !== 1'b1 && n < max_cyc) begin
         @(negedge Clk);
         n++;
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   int         hen;
   int         n;
   logic [15:0] qc;

   initial begin
      Resetn = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      pause  = 1'b0;
      target = '0;
      div    = '0;
      repeat (3) @(negedge Clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt_en", 32'(cnt_en), 32'd0);
      chk("rst_cnt_clr", 32'(cnt_clr), 32'd0);
      Resetn = 1'b1;
      @(negedge Clk);

`ifdef COUNT_CTRL_AUTO_RELOAD_EN
      // div=0, target=3: continuous reloads, done every 5 cycles, never leaves RUN.
      push_exp(3, 3, 1);
      push_exp(3, 3, 1);
      push_exp(3, 3, 1);
      launch(16'd3, 8'd0);
      wait_done(20);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin
            @(negedge Clk);
            n++;
         end while (done !== 1'b1 && n < 20);
         chk("reload_period", 32'(n), 32'd5);
      end
      stop = 1'b1;
      @(negedge Clk);
      stop = 1'b0;
      chk("reload_stop_state", 32'(state), 32'd0);
`else
      // div=0, target=5; a start pulse mid-run must be ignored.
      push_exp(5, 5, 1);
      launch(16'd5, 8'd0);
      @(negedge Clk);
      chk("clr_one_cycle", 32'(cnt_clr), 32'd0);
      target = 16'd1;
      start  = 1'b1;
      @(negedge Clk);
      start  = 1'b0;
      chk("start_ignored_clr", 32'(cnt_clr), 32'd0);
      chk("start_ignored_state", 32'(state), 32'd1);
      wait_done(50);
      @(negedge Clk);
      chk("done_pulse_width", 32'(done), 32'd0);
      chk("done_hold_state", 32'(state), 32'd3);
      chk("done_no_en", 32'(cnt_en), 32'd0);

      // div=3, target=2: increments spaced 4 cycles, restart from DONE.
      push_exp(2, 2, 4);
      launch(16'd2, 8'd3);
      wait_done(60);
      @(negedge Clk);
      chk("div3_done_width", 32'(done), 32'd0);

      // div=1, target=10 with a 7-cycle pause.
      push_exp(10, 10, 0);
      launch(16'd10, 8'd1);
      repeat (6) @(negedge Clk);
      pause = 1'b1;
      hen = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge Clk);
         if (cnt_en === 1'b1) hen++;
         if (k == 0) chk("hold_state_first", 32'(state), 32'd2);
         if (k == 6) chk("hold_state_last", 32'(state), 32'd2);
      end
      pause = 1'b0;
      chk("hold_no_en", 32'(hen), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      wait_done(80);
      @(negedge Clk);

      // stop+pause together mid-run: IDLE next edge, counter untouched.
      launch(16'd20, 8'd2);
      repeat (5) @(negedge Clk);
      n = 0;
      while (cnt_en === 1'b1 && n < 5) begin
         @(negedge Clk);
         n++;
      end
      qc    = q_m;
      stop  = 1'b1;
      pause = 1'b1;
      @(negedge Clk);
      stop  = 1'b0;
      pause = 1'b0;
      chk("stop_state", 32'(state), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_done", 32'(done), 32'd0);
      chk("stop_no_clr", 32'(cnt_clr), 32'd0);
      chk("stop_q", 32'(q_m), 32'(qc));
      @(negedge Clk);
      chk("stop_q_idle", 32'(q_m), 32'(qc));

      // target=0: DONE two cycles after the start edge, no increments.
      push_exp(0, 0, 0);
      launch(16'd0, 8'd0);
      @(negedge Clk);
      chk("t0_run", 32'(state), 32'd1);
      @(negedge Clk);
      chk("t0_done", 32'(done), 32'd1);
      chk("t0_state", 32'(state), 32'd3);
      stop = 1'b1;
      @(negedge Clk);
      stop = 1'b0;
      chk("done_stop_state", 32'(state), 32'd0);
`endif

      // Reset mid-run: outputs drop immediately, no done after release.
      launch(16'd100, 8'd0);
      repeat (4) @(negedge Clk);
      #2 Resetn = 1'b0;
      #1;
      chk("arst_cnt_en", 32'(cnt_en), 32'd0);
      chk("arst_cnt_clr", 32'(cnt_clr), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_state", 32'(state), 32'd0);
      @(negedge Clk);
      Resetn = 1'b1;
      repeat (4) @(negedge Clk);
      chk("post_rst_state", 32'(state), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
